asps_beam_direction_encoder: RTL

//  Producer side of the ASPS IR_entry/IR_exit interface. Two IR beams at the gate:

---
 rtl/asps_beam_direction_encoder_pkg.sv | 35 +++
 rtl/asps_beam_direction_encoder_if.sv | 40 ++++
 rtl/asps_beam_direction_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/asps_beam_direction_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asps_pkg
// Description : Shared types and defaults for the ASPS beam direction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package asps_pkg;

    localparam int ASPS_TIMEOUT_TICKS = 40;
    localparam int ASPS_CNT_W         = 8;

    // {beam_a, beam_b} sample encodings, 1 = blocked
    localparam logic [1:0] BEAMS_NONE = 2'b00;
    localparam logic [1:0] BEAMS_B    = 2'b01;
    localparam logic [1:0] BEAMS_A    = 2'b10;
    localparam logic [1:0] BEAMS_AB   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IN_A   = 3'd1,
        ST_IN_AB  = 3'd2,
        ST_IN_B   = 3'd3,
        ST_OUT_B  = 3'd4,
        ST_OUT_BA = 3'd5,
        ST_OUT_A  = 3'd6,
        ST_FAULT  = 3'd7
    } beam_state_t;

    // True while a passage is in progress and the watchdog timer applies
    function automatic logic is_passage_state(input beam_state_t st);
        return (st != ST_IDLE) && (st != ST_FAULT);
    endfunction

endpackage : asps_pkg
`default_nettype wire

// File: rtl/asps_beam_direction_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : asps_beam_direction_encoder_if
// Description : Beam inputs and passage event outputs of the direction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface asps_beam_direction_encoder_if #(
    parameter int CNT_W = 8
);
    logic             beam_a;
    logic             beam_b;
    logic             entry_pulse;
    logic             exit_pulse;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] abort_count;

    // Encoder side: consumes beams, produces events
    modport master (
        input  beam_a,
        input  beam_b,
        output entry_pulse,
        output exit_pulse,
        output busy,
        output fault,
        output abort_count
    );

    // Beam drivers and event consumer
    modport slave (
        output beam_a,
        output beam_b,
        input  entry_pulse,
        input  exit_pulse,
        input  busy,
        input  fault,
        input  abort_count
    );
endinterface : asps_beam_direction_encoder_if
`default_nettype wire

// File: rtl/asps_beam_direction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : asps_beam_direction_encoder
// Description : Decodes two-beam blocking order into entry/exit pulses with
//               abort counting, ambiguity rejection and stuck-beam timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module asps_beam_direction_encoder
    import asps_pkg::*;
#(
    parameter int TIMEOUT_TICKS = ASPS_TIMEOUT_TICKS,
    parameter int CNT_W         = ASPS_CNT_W
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    asps_beam_direction_encoder_if.master bus
);

    localparam int                 c_TMR_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_CAP  = c_TMR_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    generate
        if (TIMEOUT_TICKS < 2) begin : g_bad_timeout
            $error("asps_beam_direction_encoder: TIMEOUT_TICKS must be >= 2");
        end
    endgenerate

    beam_state_t        r_state;
    beam_state_t        w_next_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_abort_count;
    logic               r_entry_pulse;
    logic               r_exit_pulse;
    logic               r_busy;
    logic               r_fault;

    logic [1:0]         w_beams;
    logic               w_timeout;
    logic               w_entry;
    logic               w_exit;
    logic               w_backout;
    logic               w_abort;

    assign w_beams   = {bus.beam_a, bus.beam_b};
    assign w_timeout = is_passage_state(r_state) && (r_timer == c_TMR_LAST);

    always_comb begin
        w_next_state = r_state;
        w_entry      = 1'b0;
        w_exit       = 1'b0;
        w_backout    = 1'b0;
        w_abort      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                case (w_beams)
                    BEAMS_A:    w_next_state = ST_IN_A;
                    BEAMS_B:    w_next_state = ST_OUT_B;
                    BEAMS_AB:   w_next_state = ST_FAULT;
                    BEAMS_NONE: w_next_state = ST_IDLE;
                endcase
            end
            ST_IN_A: begin
                case (w_beams)
                    BEAMS_AB:   w_next_state = ST_IN_AB;
                    BEAMS_NONE: begin
                        w_next_state = ST_IDLE;
                        w_backout    = 1'b1;
                    end
                    BEAMS_A:    w_next_state = ST_IN_A;
                    BEAMS_B:    w_next_state = ST_FAULT;
                endcase
            end
            ST_IN_AB: begin
                case (w_beams)
                    BEAMS_B:    w_next_state = ST_IN_B;
                    BEAMS_A:    w_next_state = ST_IN_A;
                    BEAMS_AB:   w_next_state = ST_IN_AB;
                    BEAMS_NONE: w_next_state = ST_FAULT;
                endcase
            end
            ST_IN_B: begin
                case (w_beams)
                    BEAMS_NONE: begin
                        w_next_state = ST_IDLE;
                        w_entry      = 1'b1;
                    end
                    BEAMS_AB:   w_next_state = ST_IN_AB;
                    BEAMS_B:    w_next_state = ST_IN_B;
                    BEAMS_A:    w_next_state = ST_FAULT;
                endcase
            end
            ST_OUT_B: begin
                case (w_beams)
                    BEAMS_AB:   w_next_state = ST_OUT_BA;
                    BEAMS_NONE: begin
                        w_next_state = ST_IDLE;
                        w_backout    = 1'b1;
                    end
                    BEAMS_B:    w_next_state = ST_OUT_B;
                    BEAMS_A:    w_next_state = ST_FAULT;
                endcase
            end
            ST_OUT_BA: begin
                case (w_beams)
                    BEAMS_A:    w_next_state = ST_OUT_A;
                    BEAMS_B:    w_next_state = ST_OUT_B;
                    BEAMS_AB:   w_next_state = ST_OUT_BA;
                    BEAMS_NONE: w_next_state = ST_FAULT;
                endcase
            end
            ST_OUT_A: begin
                case (w_beams)
                    BEAMS_NONE: begin
                        w_next_state = ST_IDLE;
                        w_exit       = 1'b1;
                    end
                    BEAMS_AB:   w_next_state = ST_OUT_BA;
                    BEAMS_A:    w_next_state = ST_OUT_A;
                    BEAMS_B:    w_next_state = ST_FAULT;
                endcase
            end
            ST_FAULT: begin
                if (w_beams == BEAMS_NONE) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_FAULT;
        endcase

        // Watchdog overrides whatever the beams asked for this cycle
        if (w_timeout) begin
            w_next_state = ST_FAULT;
            w_entry      = 1'b0;
            w_exit       = 1'b0;
            w_backout    = 1'b0;
        end

        w_abort = w_backout || ((w_next_state == ST_FAULT) && (r_state != ST_FAULT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dwell timer: holds at the cap while parked in FAULT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if ((w_next_state != r_state) || (r_state == ST_IDLE)) begin
            r_timer <= '0;
        end else if (r_timer != c_TMR_CAP) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_abort_count <= '0;
        end else begin
            r_entry_pulse <= w_entry;
            r_exit_pulse  <= w_exit;
            r_busy        <= (w_next_state != ST_IDLE);
            r_fault       <= (w_next_state == ST_FAULT);
            if (w_abort && (r_abort_count != c_CNT_MAX)) begin
                r_abort_count <= r_abort_count + 1'b1;
            end
        end
    end

    assign bus.entry_pulse = r_entry_pulse;
    assign bus.exit_pulse  = r_exit_pulse;
    assign bus.busy        = r_busy;
    assign bus.fault       = r_fault;
    assign bus.abort_count = r_abort_count;

endmodule : asps_beam_direction_encoder
`default_nettype wire
